// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-on/off commands to NUM_VOICES NCO voices,
// steals the least-recently-allocated voice, and time-shares one tuning-code lookup.
module voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_note_on_i,
    input  logic [6:0]                cmd_note_i,
    input  logic [6:0]                cmd_velocity_i,
    output logic [6:0]                lut_note_o,
    input  logic [31:0]               lut_code_i,
    output logic [32*NUM_VOICES-1:0]  voice_code_o,
    output logic [NUM_VOICES-1:0]     voice_gate_o,
    output logic [7*NUM_VOICES-1:0]   voice_velocity_o
);
    localparam int IW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

    state_t              state_q, state_d;
    logic                cmd_on_q;
    logic [6:0]          cmd_note_q, cmd_vel_q;
    logic [IW-1:0]       target_q, target_d;
    logic [NUM_VOICES-1:0] gate_q;
    logic [6:0]          note_q [NUM_VOICES];
    logic [6:0]          vel_q  [NUM_VOICES];
    logic [31:0]         code_q [NUM_VOICES];
    logic [IW-1:0]       rank_q [NUM_VOICES];

    logic                accept;
    logic                hit_found, free_found;
    logic [IW-1:0]       hit_idx, free_idx, old_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = SEARCH;
            end
            SEARCH:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = cmd_valid_i && cmd_ready_o;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        old_idx    = '0;
        for (int v = NUM_VOICES-1; v >= 0; v--) begin
            if (gate_q[v] && note_q[v] == cmd_note_q) begin
                hit_found = 1'b1;
                hit_idx   = IW'(v);
            end
            if (!gate_q[v]) begin
                free_found = 1'b1;
                free_idx   = IW'(v);
            end
            if (rank_q[v] == IW'(NUM_VOICES-1)) old_idx = IW'(v);
        end
        target_d = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_on_q   <= 1'b0;
            cmd_note_q <= '0;
            cmd_vel_q  <= '0;
            target_q   <= '0;
        end else begin
            if (accept) begin
                cmd_on_q   <= cmd_note_on_i && (cmd_velocity_i != 7'd0);
                cmd_note_q <= cmd_note_i;
                cmd_vel_q  <= cmd_velocity_i;
            end
            if (state_q == SEARCH) target_q <= target_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gate_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                vel_q[v]  <= '0;
                code_q[v] <= '0;
                rank_q[v] <= IW'(NUM_VOICES-1-v);
            end
        end else if (state_q == COMMIT) begin
            if (cmd_on_q) begin
                // Age every voice younger than the target; target becomes newest.
                for (int v = 0; v < NUM_VOICES; v++)
                    if (rank_q[v] < rank_q[target_q]) rank_q[v] <= rank_q[v] + 1'b1;
                rank_q[target_q] <= '0;
                code_q[target_q] <= lut_code_i;
                note_q[target_q] <= cmd_note_q;
                vel_q[target_q]  <= cmd_vel_q;
                gate_q[target_q] <= 1'b1;
            end else begin
                for (int v = 0; v < NUM_VOICES; v++)
                    if (gate_q[v] && note_q[v] == cmd_note_q) gate_q[v] <= 1'b0;
            end
        end
    end

    assign lut_note_o   = cmd_note_q;
    assign voice_gate_o = gate_q;

    always_comb begin
        voice_code_o     = '0;
        voice_velocity_o = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_code_o[32*v +: 32]    = code_q[v];
            voice_velocity_o[7*v +: 7]  = vel_q[v];
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator with a small tuning-code lookup model.
module tb_voice_allocator;
    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_note_on;
    logic [6:0]      cmd_note, cmd_velocity, lut_note;
    logic [31:0]     lut_code;
    logic [32*NV-1:0] voice_code;
    logic [NV-1:0]   voice_gate;
    logic [7*NV-1:0] voice_velocity;

    int n_cmp = 0;
    int n_err = 0;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_note_on_i(cmd_note_on), .cmd_note_i(cmd_note), .cmd_velocity_i(cmd_velocity),
        .lut_note_o(lut_note), .lut_code_i(lut_code),
        .voice_code_o(voice_code), .voice_gate_o(voice_gate), .voice_velocity_o(voice_velocity)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lut_fn(input logic [6:0] n);
        case (n)
            7'd60:   lut_fn = 32'd23410;
            7'd62:   lut_fn = 32'd26277;
            7'd64:   lut_fn = 32'd29495;
            7'd65:   lut_fn = 32'd31248;
            7'd67:   lut_fn = 32'd35075;
            7'd69:   lut_fn = 32'd39371;
            7'd72:   lut_fn = 32'd46820;
            default: lut_fn = 32'h0000_ABCD;
        endcase
    endfunction

    always_comb lut_code = lut_fn(lut_note);

    function automatic logic [31:0] code_of(input int v);
        code_of = voice_code[32*v +: 32];
    endfunction
    function automatic logic [6:0] vel_of(input int v);
        vel_of = voice_velocity[7*v +: 7];
    endfunction

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_note_on = 1'b0; cmd_note = '0; cmd_velocity = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one command, returns #1 after the accept edge.
    task automatic issue(input logic on, input logic [6:0] note, input logic [6:0] vel);
        int k;
        k = 0;
        while (!cmd_ready && k < 10) begin @(posedge clk); #1; k++; end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_note_on = on; cmd_note = note; cmd_velocity = vel;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Full command: returns #1 after edge N+2, when the commit is visible.
    task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
        issue(on, note, vel);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b exp 1", cmd_ready); end
        n_cmp++; if (voice_gate !== '0) begin n_err++; $display("FAIL reset_gate: got %b exp 0", voice_gate); end
        n_cmp++; if (voice_code !== '0) begin n_err++; $display("FAIL reset_code: got %h exp 0", voice_code); end
        n_cmp++; if (voice_velocity !== '0) begin n_err++; $display("FAIL reset_vel: got %h exp 0", voice_velocity); end
        n_cmp++; if (lut_note !== 7'd0) begin n_err++; $display("FAIL reset_lut_note: got %0d exp 0", lut_note); end
    endtask

    task automatic test_first_note();
        do_reset();
        issue(1'b1, 7'd69, 7'd100);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL first_ready_n1: got %0b exp 0", cmd_ready); end
        n_cmp++; if (voice_gate[0] !== 1'b0) begin n_err++; $display("FAIL first_gate_early: got %0b exp 0", voice_gate[0]); end
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL first_ready_n2: got %0b exp 0", cmd_ready); end
        n_cmp++; if (voice_gate[0] !== 1'b0) begin n_err++; $display("FAIL first_gate_n1: got %0b exp 0", voice_gate[0]); end
        n_cmp++; if (lut_note !== 7'd69) begin n_err++; $display("FAIL first_lut_note: got %0d exp 69", lut_note); end
        @(posedge clk); #1;
        n_cmp++; if (voice_gate !== 4'b0001) begin n_err++; $display("FAIL first_gate: got %b exp 0001", voice_gate); end
        n_cmp++; if (code_of(0) !== 32'd39371) begin n_err++; $display("FAIL first_code: got %0d exp 39371", code_of(0)); end
        n_cmp++; if (vel_of(0) !== 7'd100) begin n_err++; $display("FAIL first_vel: got %0d exp 100", vel_of(0)); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL first_ready_n3: got %0b exp 1", cmd_ready); end
    endtask

    task automatic test_chord();
        do_reset();
        send(1'b1, 7'd60, 7'd80);
        send(1'b1, 7'd64, 7'd80);
        send(1'b1, 7'd67, 7'd80);
        n_cmp++; if (voice_gate !== 4'b0111) begin n_err++; $display("FAIL chord_gate: got %b exp 0111", voice_gate); end
        n_cmp++; if (code_of(0) !== 32'd23410) begin n_err++; $display("FAIL chord_code0: got %0d exp 23410", code_of(0)); end
        n_cmp++; if (code_of(1) !== 32'd29495) begin n_err++; $display("FAIL chord_code1: got %0d exp 29495", code_of(1)); end
        n_cmp++; if (code_of(2) !== 32'd35075) begin n_err++; $display("FAIL chord_code2: got %0d exp 35075", code_of(2)); end
        n_cmp++; if (code_of(3) !== 32'd0) begin n_err++; $display("FAIL chord_code3: got %0d exp 0", code_of(3)); end
    endtask

    task automatic test_steal();
        do_reset();
        send(1'b1, 7'd60, 7'd10);
        send(1'b1, 7'd62, 7'd20);
        send(1'b1, 7'd64, 7'd30);
        send(1'b1, 7'd65, 7'd40);
        send(1'b1, 7'd67, 7'd55);
        n_cmp++; if (code_of(0) !== 32'd35075) begin n_err++; $display("FAIL steal1_code: got %0d exp 35075", code_of(0)); end
        n_cmp++; if (vel_of(0) !== 7'd55) begin n_err++; $display("FAIL steal1_vel: got %0d exp 55", vel_of(0)); end
        n_cmp++; if (voice_gate !== 4'b1111) begin n_err++; $display("FAIL steal1_gate: got %b exp 1111", voice_gate); end
        send(1'b1, 7'd69, 7'd66);
        n_cmp++; if (code_of(1) !== 32'd39371) begin n_err++; $display("FAIL steal2_code: got %0d exp 39371", code_of(1)); end
        n_cmp++; if (code_of(2) !== 32'd29495 || code_of(3) !== 32'd31248) begin
            n_err++; $display("FAIL steal2_others: got %0d/%0d exp 29495/31248", code_of(2), code_of(3)); end
    endtask

    task automatic test_note_off();
        do_reset();
        send(1'b1, 7'd60, 7'd70);
        send(1'b0, 7'd60, 7'd70);
        n_cmp++; if (voice_gate[0] !== 1'b0) begin n_err++; $display("FAIL off_gate: got %0b exp 0", voice_gate[0]); end
        n_cmp++; if (code_of(0) !== 32'd23410 || vel_of(0) !== 7'd70) begin
            n_err++; $display("FAIL off_keep: code %0d vel %0d exp 23410 70", code_of(0), vel_of(0)); end
        send(1'b0, 7'd61, 7'd0);
        n_cmp++; if (voice_gate !== 4'b0000 || code_of(0) !== 32'd23410) begin
            n_err++; $display("FAIL off_nomatch: gate %b code %0d exp 0000 23410", voice_gate, code_of(0)); end
        send(1'b1, 7'd60, 7'd70);
        send(1'b1, 7'd60, 7'd0);
        n_cmp++; if (voice_gate !== 4'b0000 || vel_of(0) !== 7'd70) begin
            n_err++; $display("FAIL vel0_off: gate %b vel %0d exp 0000 70", voice_gate, vel_of(0)); end
    endtask

    task automatic test_retrigger();
        do_reset();
        send(1'b1, 7'd60, 7'd50);
        send(1'b1, 7'd64, 7'd30);
        send(1'b1, 7'd60, 7'd90);
        n_cmp++; if (voice_gate !== 4'b0011 || vel_of(0) !== 7'd90) begin
            n_err++; $display("FAIL retrig_v0: gate %b vel %0d exp 0011 90", voice_gate, vel_of(0)); end
        n_cmp++; if (code_of(1) !== 32'd29495 || vel_of(1) !== 7'd30) begin
            n_err++; $display("FAIL retrig_v1: code %0d vel %0d exp 29495 30", code_of(1), vel_of(1)); end
        // Ranks now v0=0 v1=1 v2=3 v3=2; filling v2,v3 leaves v1 as oldest.
        send(1'b1, 7'd67, 7'd1);
        send(1'b1, 7'd69, 7'd2);
        send(1'b1, 7'd72, 7'd3);
        n_cmp++; if (code_of(1) !== 32'd46820 || code_of(0) !== 32'd23410) begin
            n_err++; $display("FAIL retrig_rank: v1 %0d v0 %0d exp 46820 23410", code_of(1), code_of(0)); end
    endtask

    task automatic test_note127();
        do_reset();
        send(1'b1, 7'd127, 7'd127);
        n_cmp++; if (lut_note !== 7'd127 || code_of(0) !== 32'h0000_ABCD) begin
            n_err++; $display("FAIL note127: lut_note %0d code %h exp 127 0000abcd", lut_note, code_of(0)); end
    endtask

    task automatic test_reset_abort();
        logic hit;
        do_reset();
        send(1'b1, 7'd60, 7'd40);
        issue(1'b1, 7'd72, 7'd40);
        rst = 1'b1; #1;
        n_cmp++; if (voice_gate !== '0 || voice_code !== '0) begin
            n_err++; $display("FAIL abort_clear: gate %b code %h exp 0 0", voice_gate, voice_code); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %0b exp 1", cmd_ready); end
        repeat (3) @(posedge clk);
        #1;
        hit = 1'b0;
        for (int v = 0; v < NV; v++) if (code_of(v) == 32'd46820) hit = 1'b1;
        n_cmp++; if (hit !== 1'b0 || voice_gate !== '0) begin
            n_err++; $display("FAIL abort_discard: hit %0b gate %b exp 0 0000", hit, voice_gate); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_note_on = 1'b0; cmd_note = '0; cmd_velocity = '0;
        test_reset();
        test_first_note();
        test_chord();
        test_steal();
        test_note_off();
        test_retrigger();
        test_note127();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
